// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and request legality check for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_RMW_RD = 2'b10,
    ST_STORE  = 2'b11
  } lsu_state_e;

  // Illegal covers ambiguous op, unsupported funct3 and natural-alignment violations.
  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = (rd == wr);
    if (rd && !wr) bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    if (wr && !rd) bad = (f3 > F3_W);
    if (!bad) begin
      if (f3[1:0] == 2'b10 && a != 2'b00) bad = 1'b1;
      if (f3[1:0] == 2'b01 && a[0])       bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the Data_Mem word port of the load/store unit.
interface load_store_unit_if #(parameter int DM_ADDR_W = 6);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_read;
  logic                 req_write;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic                 dm_read;
  logic                 dm_write;
  logic [DM_ADDR_W-1:0] dm_addr;
  logic [31:0]          dm_wdata;
  logic [31:0]          dm_rdata;

  modport slave (
    input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata, dm_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dm_read, dm_write, dm_addr, dm_wdata
  );

  modport master (
    output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata, dm_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dm_read, dm_write, dm_addr, dm_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: merges sub-word store data into a word and extends loaded lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] word_in,
  output logic [31:0] merged,
  output logic [31:0] extended
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      // Word stores (and any other size) take every lane straight from store data.
      always_comb begin
        hit = 1'b1;
        src = store_data[8*gi +: 8];
        case (funct3[1:0])
          2'b00: begin
            hit = (addr_lo == 2'(gi));
            src = store_data[7:0];
          end
          2'b01: begin
            hit = (addr_lo[1] == 1'(gi / 2));
            src = store_data[8*(gi % 2) +: 8];
          end
          default: ;
        endcase
      end
      assign merged[8*gi +: 8] = hit ? src : word_in[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_in[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];
    case (funct3)
      F3_B:    extended = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   extended = {24'h0, byte_sel};
      F3_H:    extended = {{16{half_sel[15]}}, half_sel};
      F3_HU:   extended = {16'h0, half_sel};
      default: extended = word_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer in front of a word-wide Data_Mem.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  lsu_state_e  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] word_reg;
  logic [2:0]  funct3_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;

  logic        accept;
  logic        illegal;
  logic [31:0] merged_word;
  logic [31:0] load_word;

  assign accept  = (state_reg == ST_IDLE) && bus.req_valid;
  assign illegal = req_illegal(bus.req_read, bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

  // Loads extend the live memory word; stores merge into the word captured during RMW_RD.
  lsu_lane_align u_align (
    .addr_lo    (addr_reg[1:0]),
    .funct3     (funct3_reg),
    .store_data (wdata_reg),
    .word_in    ((state_reg == ST_LOAD) ? bus.dm_rdata : word_reg),
    .merged     (merged_word),
    .extended   (load_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !illegal) begin
          if (bus.req_read)              state_next = ST_LOAD;
          else if (bus.req_funct3 == F3_W) state_next = ST_STORE;
          else                           state_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_next = ST_IDLE;
      ST_RMW_RD: state_next = ST_STORE;
      ST_STORE:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_reg == ST_IDLE);
    bus.dm_read   = (state_reg == ST_LOAD) || (state_reg == ST_RMW_RD);
    bus.dm_write  = (state_reg == ST_STORE);
    bus.dm_addr   = (state_reg == ST_IDLE) ? '0 : addr_reg[DM_ADDR_W+1:2];
    bus.dm_wdata  = (state_reg == ST_STORE) ? merged_word : 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      word_reg   <= 32'h0;
      funct3_reg <= 3'b000;
    end else begin
      if (accept) begin
        addr_reg   <= bus.req_addr;
        wdata_reg  <= bus.req_wdata;
        funct3_reg <= bus.req_funct3;
      end
      if (state_reg == ST_RMW_RD) word_reg <= bus.dm_rdata;
    end
  end

  // resp_rdata is only rewritten on a response, so load data stays visible until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
    end else begin
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      if (accept && illegal) begin
        resp_valid_reg <= 1'b1;
        resp_err_reg   <= 1'b1;
        resp_rdata_reg <= 32'h0;
      end else if (state_reg == ST_LOAD) begin
        resp_valid_reg <= 1'b1;
        resp_rdata_reg <= load_word;
      end else if (state_reg == ST_STORE) begin
        resp_valid_reg <= 1'b1;
        resp_rdata_reg <= 32'h0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;

endmodule
